pmem_arb: RTL and testbench

- Two-master arbiter that shares the single physical-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one request at a time, sequences it onto the downstream valid/ready memory port, captures the response and returns it to the granted master.
- Sits between the IFU/LSU and the pmem access block (DPI-backed in simulation).

---
 rtl/pmem_pkg.sv | 17 +
 rtl/pmem_arb_pick.sv | 37 +++
 rtl/pmem_arb.sv | 165 ++++++++++++++++
 tb/tb_pmem_arb.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared definitions for the physical-memory arbiter.
// FSM state codes, owner encoding and the timeout fill pattern.
package pmem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/pmem_arb_pick.sv
// Winner selection between IFU and LSU with an LSU run limiter.
// The run counter stops the LSU from starving instruction fetch.
module pmem_arb_pick #(
    parameter int LSU_MAX_RUN = 4
) (
    input  logic       if_valid,
    input  logic       ls_valid,
    input  logic [3:0] run_cnt,
    output logic       if_win,
    output logic       ls_win,
    output logic [3:0] run_nxt
);

    localparam logic [3:0] RUN_MAX = 4'(LSU_MAX_RUN);

    logic at_max;

    assign at_max = (run_cnt == RUN_MAX);

    // LSU has priority unless the IFU has waited out a full LSU run
    always_comb begin
        if_win  = 1'b0;
        ls_win  = 1'b0;
        run_nxt = run_cnt;
        if (ls_valid && !(if_valid && at_max)) begin
            ls_win = 1'b1;
        end else if (if_valid) begin
            if_win = 1'b1;
        end
        if (if_win) begin
            run_nxt = 4'd0;
        end else if (ls_win && if_valid && !at_max) begin
            run_nxt = run_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/pmem_arb.sv
// Two-master (IFU/LSU) arbiter onto one valid/ready memory port.
// Optional WAIT timeout with err pulse: define PMEM_ARB_TIMEOUT_EN.
module pmem_arb
    import pmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LSU_MAX_RUN = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_valid,
    output logic                ls_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
`ifdef PMEM_ARB_TIMEOUT_EN
    output logic                err,
`endif
    output logic                busy
);

    state_t              state;
    logic                owner;
    logic [3:0]          run_cnt;
    logic [3:0]          run_nxt;
    logic [DATA_W-1:0]   cap;
    logic                if_win;
    logic                ls_win;
    logic                acc;
    logic                idle;
    logic                req_done;
    logic                wait_done;

    pmem_arb_pick #(
        .LSU_MAX_RUN (LSU_MAX_RUN)
    ) u_pick (
        .if_valid (if_valid),
        .ls_valid (ls_valid),
        .run_cnt  (run_cnt),
        .if_win   (if_win),
        .ls_win   (ls_win),
        .run_nxt  (run_nxt)
    );

    assign idle     = (state == ST_IDLE) && !rst;
    assign if_ready = idle && if_win;
    assign ls_ready = idle && ls_win;
    assign acc      = if_ready || ls_ready;

    assign req_done  = (state == ST_REQ) && mem_ready && mem_rvalid;
    assign wait_done = (state == ST_WAIT) && mem_rvalid;

    assign mem_valid = (state == ST_REQ);
    assign busy      = (state != ST_IDLE);
    assign if_rvalid = (state == ST_RESP) && (owner == OWN_IFU);
    assign ls_rvalid = (state == ST_RESP) && (owner == OWN_LSU);
    assign if_rdata  = if_rvalid ? cap : '0;
    assign ls_rdata  = ls_rvalid ? cap : '0;

`ifdef PMEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(TIMEOUT_DATA);

    logic [TW-1:0] wcnt;
    logic          to_hit;
    logic          to_flag;

    assign to_hit = (state == ST_WAIT) && !mem_rvalid && (wcnt == TO_LAST);
    assign err    = (state == ST_RESP) && to_flag;

    // WAIT-cycle counter, restarted each time WAIT is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt    <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state == ST_REQ) begin
                wcnt <= '0;
            end else if (state == ST_WAIT) begin
                wcnt <= wcnt + 1'b1;
            end
            if (acc) begin
                to_flag <= 1'b0;
            end else if (to_hit) begin
                to_flag <= 1'b1;
            end
        end
    end
`else
    logic to_hit;

    assign to_hit = 1'b0;
`endif

    // Transaction FSM: IDLE -> REQ -> (WAIT) -> RESP -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (acc) state <= ST_REQ;
                ST_REQ: begin
                    if (mem_ready) begin
                        state <= mem_rvalid ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: if (mem_rvalid || to_hit) state <= ST_RESP;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Latch the granted request and its owner on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            run_cnt   <= 4'd0;
        end else if (acc) begin
            owner     <= ls_ready ? OWN_LSU : OWN_IFU;
            mem_addr  <= ls_ready ? ls_addr : if_addr;
            mem_wen   <= ls_ready && ls_wen;
            mem_wdata <= ls_ready ? ls_wdata : '0;
            mem_wmask <= ls_ready ? ls_wmask : '0;
            run_cnt   <= run_nxt;
        end
    end

    // Capture response data; writes return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap <= '0;
        end else if (req_done || wait_done) begin
            cap <= mem_wen ? '0 : mem_rdata;
`ifdef PMEM_ARB_TIMEOUT_EN
        end else if (to_hit) begin
            cap <= TO_DATA;
`endif
        end
    end

endmodule

// File: tb/tb_pmem_arb.sv
// Scoreboard bench for pmem_arb with a behavioural memory responder.
// Define PMEM_ARB_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_pmem_arb;

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  m;
    } mreq_t;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_valid;
    logic        ls_ready;
    logic [31:0] ls_addr;
    logic        ls_wen;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
`ifdef PMEM_ARB_TIMEOUT_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ifq[$];
    mreq_t       lsq[$];
    logic [31:0] if_exp[$];
    logic [31:0] ls_exp[$];
    mreq_t       mem_exp[$];
    bit          glog[$];

    int  stall = 0;
    int  lat = 1;
    int  late_req = 0;
    bit  to_mode = 0;
    int  cyc = 0;
    int  busy_cyc = 0;
    int  if_acc = 0;
    int  ls_acc = 0;
    int  if_lat = 0;
    int  ls_lat = 0;
    int  hs_cyc = 0;
    int  ls_rv_cyc = 0;
    int  if_rv_cnt = 0;
    int  ls_rv_cnt = 0;
    int  err_cnt = 0;

    pmem_arb #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .LSU_MAX_RUN (4),
        .TIMEOUT     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_addr    (if_addr),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_valid   (ls_valid),
        .ls_ready   (ls_ready),
        .ls_addr    (ls_addr),
        .ls_wen     (ls_wen),
        .ls_wdata   (ls_wdata),
        .ls_wmask   (ls_wmask),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
`ifdef PMEM_ARB_TIMEOUT_EN
        .err        (err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        rd = (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h3C5A_96E1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n = 0;
        while ((ifq.size() != 0 || lsq.size() != 0 || if_exp.size() != 0 ||
                ls_exp.size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < max), 64'd1);
        @(negedge clk);
    endtask

    // IFU master
    initial begin
        if_valid = 1'b0;
        if_addr  = '0;
        forever begin
            @(negedge clk);
            if (if_valid && if_ready) begin
                if_exp.push_back(rd(if_addr));
                mem_exp.push_back('{if_addr, 1'b0, 32'h0, 4'h0});
                void'(ifq.pop_front());
            end
            @(posedge clk);
            #1;
            if (ifq.size() != 0) begin
                if_valid = 1'b1;
                if_addr  = ifq[0];
            end else begin
                if_valid = 1'b0;
            end
        end
    end

    // LSU master
    initial begin
        ls_valid = 1'b0;
        ls_addr  = '0;
        ls_wen   = 1'b0;
        ls_wdata = '0;
        ls_wmask = '0;
        forever begin
            @(negedge clk);
            if (ls_valid && ls_ready) begin
                if (to_mode) ls_exp.push_back(32'hDEAD_BEEF);
                else ls_exp.push_back(ls_wen ? 32'h0 : rd(ls_addr));
                mem_exp.push_back('{ls_addr, ls_wen, ls_wdata, ls_wmask});
                void'(lsq.pop_front());
            end
            @(posedge clk);
            #1;
            if (lsq.size() != 0) begin
                ls_valid = 1'b1;
                ls_addr  = lsq[0].a;
                ls_wen   = lsq[0].w;
                ls_wdata = lsq[0].d;
                ls_wmask = lsq[0].m;
            end else begin
                ls_valid = 1'b0;
            end
        end
    end

    // Memory responder
    initial begin
        int          late_ack;
        logic [31:0] ra;
        logic        rw;
        late_ack   = 0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (late_req != late_ack) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0_BAD0;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                late_ack++;
            end else if (mem_valid) begin
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
                ra = mem_addr;
                rw = mem_wen;
                mem_ready = 1'b1;
                if (lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rw ? 32'hFFFF_FFFF : rd(ra);
                end
                @(posedge clk);
                #1;
                mem_ready  = 1'b0;
                mem_rvalid = 1'b0;
                if (lat > 0) begin
                    repeat (lat - 1) begin
                        @(posedge clk);
                        #1;
                    end
                    mem_rvalid = 1'b1;
                    mem_rdata  = rw ? 32'hFFFF_FFFF : rd(ra);
                    @(posedge clk);
                    #1;
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Monitor: grant log, request fields, responses
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (if_valid && if_ready) begin
                glog.push_back(1'b1);
                if_acc = cyc;
            end
            if (ls_valid && ls_ready) begin
                glog.push_back(1'b0);
                ls_acc = cyc;
            end
            if (if_ready && ls_ready) chk("both_ready", 64'd1, 64'd0);
            if (mem_valid) begin
                if (mem_exp.size() == 0) begin
                    chk("mem_spur", 64'd1, 64'd0);
                end else begin
                    chk("mem_addr", 64'(mem_addr), 64'(mem_exp[0].a));
                    chk("mem_wen", 64'(mem_wen), 64'(mem_exp[0].w));
                    chk("mem_wmask", 64'(mem_wmask), 64'(mem_exp[0].m));
                    if (mem_exp[0].w)
                        chk("mem_wdata", 64'(mem_wdata), 64'(mem_exp[0].d));
                    if (mem_ready) begin
                        hs_cyc = cyc;
                        void'(mem_exp.pop_front());
                    end
                end
            end
            if (if_rvalid) begin
                if_rv_cnt++;
                if_lat = cyc - if_acc;
                if (if_exp.size() == 0) chk("if_spur", 64'd1, 64'd0);
                else chk("if_rdata", 64'(if_rdata), 64'(if_exp.pop_front()));
            end
            if (ls_rvalid) begin
                ls_rv_cnt++;
                ls_lat = cyc - ls_acc;
                ls_rv_cyc = cyc;
                if (ls_exp.size() == 0) chk("ls_spur", 64'd1, 64'd0);
                else chk("ls_rdata", 64'(ls_rdata), 64'(ls_exp.pop_front()));
            end
`ifdef PMEM_ARB_TIMEOUT_EN
            if (err) begin
                err_cnt++;
                chk("err_with_rv", 64'(if_rvalid || ls_rvalid), 64'd1);
            end
`endif
        end
    end

    initial begin
        int b0;
        int rv0;
        int n;
        mreq_t r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outs", {mem_valid, busy, if_rvalid, ls_rvalid,
                         if_ready, ls_ready}, 64'd0);
        chk("rst_mem", {mem_addr, mem_wen, mem_wmask}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // IFU read alone
        b0 = busy_cyc;
        ifq.push_back(32'h8000_0000);
        wait_drain("t1_drain", 50);
        chk("t1_lat", 64'(if_lat), 64'd3);
        chk("t1_busy", 64'(busy_cyc - b0), 64'd3);

        // simultaneous IFU + LSU
        glog.delete();
        ifq.push_back(32'h8000_0004);
        lsq.push_back('{32'h8000_1000, 1'b0, 32'h0, 4'h0});
        wait_drain("t2_drain", 50);
        chk("t2_n", 64'(glog.size()), 64'd2);
        if (glog.size() == 2) begin
            chk("t2_first_ls", 64'(glog[0]), 64'd0);
            chk("t2_then_if", 64'(glog[1]), 64'd1);
        end

        // best-case same-cycle response
        lat = 0;
        lsq.push_back('{32'h8000_1010, 1'b0, 32'h0, 4'h0});
        wait_drain("t2b_drain", 50);
        chk("t2b_lat", 64'(ls_lat), 64'd2);

        // starvation limiter
        glog.delete();
        for (int i = 0; i < 12; i++)
            lsq.push_back('{32'h8000_2000 + 32'(i * 4), 1'b0, 32'h0, 4'h0});
        for (int i = 0; i < 3; i++)
            ifq.push_back(32'h8000_0100 + 32'(i * 4));
        wait_drain("t3_drain", 200);
        chk("t3_n", 64'(glog.size()), 64'd15);
        n = (glog.size() < 15) ? glog.size() : 15;
        for (int i = 0; i < n; i++)
            chk("t3_grant", 64'(glog[i]), 64'((i % 5) == 4));

        // write held through stalls
        stall = 3;
        lat = 1;
        lsq.push_back('{32'h8000_3000, 1'b1, 32'h1234_5678, 4'b0011});
        wait_drain("t4_drain", 50);

        // mixed random traffic
        stall = 1;
        lat = 2;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1) == 1) begin
                ifq.push_back({16'h8000, 16'($urandom) & 16'hFFFC});
            end else begin
                r.a = {16'h9000, 16'($urandom) & 16'hFFFC};
                r.w = 1'($urandom_range(1));
                r.d = $urandom;
                r.m = 4'($urandom);
                lsq.push_back(r);
            end
        end
        wait_drain("rand_drain", 500);

        // reset while waiting for the response
        stall = 0;
        lat = -1;
        lsq.push_back('{32'h8000_4000, 1'b0, 32'h0, 4'h0});
        n = 0;
        while (!(busy && !mem_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_in_wait", 64'(n < 20), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_outs", {mem_valid, busy, ls_rvalid, if_rvalid,
                        if_ready, ls_ready}, 64'd0);
        chk("t5_mem", {mem_addr, mem_wen, mem_wmask}, 64'd0);
        chk("t5_rdata", {if_rdata, ls_rdata}, 64'd0);
        ls_exp.delete();
        mem_exp.delete();
        @(negedge clk);
        rst = 1'b0;
        rv0 = if_rv_cnt + ls_rv_cnt;
        late_req++;
        repeat (6) @(negedge clk);
        chk("t5_no_rv", 64'(if_rv_cnt + ls_rv_cnt - rv0), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);

`ifdef PMEM_ARB_TIMEOUT_EN
        // WAIT timeout
        to_mode = 1'b1;
        lsq.push_back('{32'h8000_5000, 1'b0, 32'h0, 4'h0});
        wait_drain("t6_drain", 50);
        chk("t6_err_n", 64'(err_cnt), 64'd1);
        chk("t6_timing", 64'(ls_rv_cyc - hs_cyc), 64'd9);
        to_mode = 1'b0;
`endif

        chk("left_mem_exp", 64'(mem_exp.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1);
    end

endmodule
